ect_sync_demod: RTL

Square-wave quadrature demodulator for one ECT measurement channel. It sits directly upstream of the one-shot demodulation request/UART stage, which raises `DemodEn` and later reads `DemodResult`. On each request the block aligns to the excitation phase marker and accumulates `NumPeriods` excitation periods of ADC samples against ±1 in-phase and quadrature references. It then presents |I|+|Q| as a 32-bit result under a level handshake. One instance is used per channel.

---
 rtl/ect_pkg.sv | 25 ++
 rtl/demod_ref_gen.sv | 42 ++++
 rtl/ect_sync_demod.sv | 101 ++++++++++
 3 files changed

// File: rtl/ect_pkg.sv
// rtl/ect_pkg.sv - shared ECT types, widths and offset-binary sample conversion
package ect_pkg;

    localparam int DEMOD_ACC_W = 32;
    localparam int DEMOD_RES_W = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
    localparam logic [2:0] ST_ACC       = 3'd2;
    localparam logic [2:0] ST_MAG       = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Caller passes the raw word zero-extended; the flipped MSB is then sign-extended.
    function automatic logic signed [DEMOD_ACC_W-1:0] ob_to_signed(
        input logic [DEMOD_ACC_W-1:0] raw,
        input int unsigned            width
    );
        logic [DEMOD_ACC_W-1:0]        flipped;
        logic signed [DEMOD_ACC_W-1:0] shl;
        flipped = raw ^ (DEMOD_ACC_W'(1) << (width - 1));
        shl     = signed'(flipped << (DEMOD_ACC_W - width));
        return shl >>> (DEMOD_ACC_W - width);
    endfunction

endpackage

// File: rtl/demod_ref_gen.sv
// rtl/demod_ref_gen.sv - phase/period counters and square-wave I/Q references
module demod_ref_gen #(
    parameter int SampPerPeriod = 64,
    parameter int NumPeriods    = 16
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_ref_i,
    output logic o_ref_q,
    output logic o_last
);

    localparam int PhW  = $clog2(SampPerPeriod);
    localparam int PerW = (NumPeriods > 1) ? $clog2(NumPeriods) : 1;

    logic [PhW-1:0]  r_phase;
    logic [PerW-1:0] r_period;
    logic            w_wrap;

    assign w_wrap = (r_phase == PhW'(SampPerPeriod - 1));

    // Both counts are powers of two, so the phase wraps without an explicit reload.
    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_clear) begin
            r_phase  <= '0;
            r_period <= '0;
        end else if (i_advance) begin
            r_phase <= r_phase + PhW'(1);
            if (w_wrap) begin
                r_period <= r_period + PerW'(1);
            end
        end
    end

    // I is +1 in the first half period; Q is +1 in the middle two quarters.
    assign o_ref_i = ~r_phase[PhW-1];
    assign o_ref_q = r_phase[PhW-1] ^ r_phase[PhW-2];
    assign o_last  = w_wrap && (r_period == PerW'(NumPeriods - 1));

endmodule

// File: rtl/ect_sync_demod.sv
// rtl/ect_sync_demod.sv - sync-aligned square-wave I/Q demodulator, |I|+|Q| result
module ect_sync_demod
    import ect_pkg::*;
#(
    parameter int SampPerPeriod = 64,
    parameter int NumPeriods    = 16,
    parameter int AdcWidth      = 14
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   DemodEn,
    input  logic                   ADCValid,
    input  logic [AdcWidth-1:0]    ADCDat,
    input  logic                   SyncIn,
    output logic                   DemodReady,
    output logic [DEMOD_RES_W-1:0] DemodResult
);

    logic [2:0]                    r_state;
    logic [2:0]                    w_state_nxt;
    logic signed [DEMOD_ACC_W-1:0] r_acc_i;
    logic signed [DEMOD_ACC_W-1:0] r_acc_q;
    logic signed [DEMOD_ACC_W-1:0] w_sample;
    logic [DEMOD_ACC_W-1:0]        w_abs_i;
    logic [DEMOD_ACC_W-1:0]        w_abs_q;
    logic [DEMOD_RES_W-1:0]        w_mag;
    logic                          w_accept;
    logic                          w_clear;
    logic                          w_ref_i;
    logic                          w_ref_q;
    logic                          w_last;

    assign w_sample = ob_to_signed(DEMOD_ACC_W'(ADCDat), AdcWidth);

    // The sync sample itself is accumulated as phase 0; later SyncIn is ignored.
    assign w_accept = DemodEn && ADCValid &&
                      (((r_state == ST_WAIT_SYNC) && SyncIn) || (r_state == ST_ACC));
    assign w_clear  = !DemodEn || (r_state == ST_IDLE);

    demod_ref_gen #(
        .SampPerPeriod(SampPerPeriod),
        .NumPeriods   (NumPeriods)
    ) u_ref_gen (
        .i_clk    (Clk),
        .i_resetn (Rst),
        .i_clear  (w_clear),
        .i_advance(w_accept),
        .o_ref_i  (w_ref_i),
        .o_ref_q  (w_ref_q),
        .o_last   (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!DemodEn) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_nxt = ST_WAIT_SYNC;
                ST_WAIT_SYNC: if (w_accept) w_state_nxt = ST_ACC;
                ST_ACC:       if (w_accept && w_last) w_state_nxt = ST_MAG;
                ST_MAG:       w_state_nxt = ST_DONE;
                ST_DONE:      w_state_nxt = ST_DONE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_abs_i = r_acc_i[DEMOD_ACC_W-1] ? DEMOD_ACC_W'(-r_acc_i) : DEMOD_ACC_W'(r_acc_i);
    assign w_abs_q = r_acc_q[DEMOD_ACC_W-1] ? DEMOD_ACC_W'(-r_acc_q) : DEMOD_ACC_W'(r_acc_q);
    assign w_mag   = DEMOD_RES_W'(w_abs_i + w_abs_q);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            DemodReady  <= 1'b0;
            DemodResult <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_clear) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else if (w_accept) begin
                r_acc_i <= w_ref_i ? (r_acc_i + w_sample) : (r_acc_i - w_sample);
                r_acc_q <= w_ref_q ? (r_acc_q + w_sample) : (r_acc_q - w_sample);
            end

            // Result is only rewritten by a completed measurement; ready alone qualifies it.
            if (!DemodEn) begin
                DemodReady <= 1'b0;
            end else if (r_state == ST_MAG) begin
                DemodResult <= w_mag;
                DemodReady  <= 1'b1;
            end
        end
    end

endmodule
